// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_n
//  Purpose  : N-input, WIDTH-bit registered multiplexer with per-channel
//             valid/ready handshake. A grant is chosen either from an
//             external static index or by round-robin among valid channels.
//             The winner is captured into a single output register stage.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk    in   1            clock, rising edge
//    i_rst_n  in   1            asynchronous active-low reset
//    i_mode   in   1            0 = static select, 1 = round-robin
//    i_sel    in   SEL_W        channel index for static mode
//    i_valid  in   N_IN         per-channel data valid
//    i_data   in   N_IN*WIDTH   packed channel data, ch k at [k*WIDTH +: WIDTH]
//    o_ready  out  N_IN         per-channel accept strobe
//    o_valid  out  1            output register holds valid data
//    o_data   out  WIDTH        registered selected data
//    o_src    out  SEL_W        channel that produced o_data
//    i_ready  in   1            downstream accepts o_data
// ============================================================================
module mux_arb_n #(
   parameter int  WIDTH = 16,
   parameter int  N_IN  = 4,
   localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_mode,
   input  logic [SEL_W-1:0]      i_sel,
   input  logic [N_IN-1:0]       i_valid,
   input  logic [N_IN*WIDTH-1:0] i_data,
   output logic [N_IN-1:0]       o_ready,
   output logic                  o_valid,
   output logic [WIDTH-1:0]      o_data,
   output logic [SEL_W-1:0]      o_src,
   input  logic                  i_ready
);

   localparam logic [SEL_W-1:0] C_PTR_RST = SEL_W'(N_IN - 1);

   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [SEL_W-1:0]   src_q,   src_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               w_load_en;
   logic               w_gnt_vld;
   logic [SEL_W-1:0]   w_gnt_idx;
   logic [WIDTH-1:0]   w_gnt_data;

   // Register is free when empty or being drained on this same edge.
   assign w_load_en = !valid_q || i_ready;

   // ------------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------------
   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt_idx  = '0;
      w_gnt_data = '0;
      if (!i_mode) begin
         // An out-of-range i_sel never matches any k, so it simply grants nothing.
         for (int k = 0; k < N_IN; k++) begin
            if (i_sel == SEL_W'(k) && i_valid[k]) begin
               w_gnt_vld  = 1'b1;
               w_gnt_idx  = SEL_W'(k);
               w_gnt_data = i_data[k*WIDTH +: WIDTH];
            end
         end
      end else begin
         // Round-robin search from rr_ptr+1 with wrap. Two descending passes:
         // the first picks the lowest valid channel at or below the pointer
         // (the wrapped-around part), the second overrides it with the lowest
         // valid channel above the pointer, which has priority.
         for (int k = N_IN - 1; k >= 0; k--) begin
            if (i_valid[k] && (SEL_W'(k) <= rr_ptr_q)) begin
               w_gnt_vld  = 1'b1;
               w_gnt_idx  = SEL_W'(k);
               w_gnt_data = i_data[k*WIDTH +: WIDTH];
            end
         end
         for (int k = N_IN - 1; k >= 0; k--) begin
            if (i_valid[k] && (SEL_W'(k) > rr_ptr_q)) begin
               w_gnt_vld  = 1'b1;
               w_gnt_idx  = SEL_W'(k);
               w_gnt_data = i_data[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-channel accept strobe (one-hot or zero)
   // ------------------------------------------------------------------------
   always_comb begin
      o_ready = '0;
      for (int k = 0; k < N_IN; k++) begin
         o_ready[k] = w_load_en && w_gnt_vld && (w_gnt_idx == SEL_W'(k));
      end
   end

   // ------------------------------------------------------------------------
   // Next-state for the output stage and round-robin pointer
   // ------------------------------------------------------------------------
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      src_d    = src_q;
      rr_ptr_d = rr_ptr_q;
      if (w_load_en) begin
         if (w_gnt_vld) begin
            valid_d = 1'b1;
            data_d  = w_gnt_data;
            src_d   = w_gnt_idx;
            // Only round-robin transfers move the fairness pointer.
            if (i_mode) begin
               rr_ptr_d = w_gnt_idx;
            end
         end else begin
            // Drained (or still empty) with nothing to load; data/src keep
            // their last value.
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         src_q    <= '0;
         rr_ptr_q <= C_PTR_RST;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         src_q    <= src_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_src   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arb_n
//  Purpose  : Self-checking bench for mux_arb_n (N_IN=4 main instance plus an
//             N_IN=3 instance for the out-of-range static select case).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_n;

   localparam int WIDTH = 16;

   logic        clk;
   logic        rst_n;

   // N_IN = 4 instance
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  valid;
   logic [63:0] data;
   logic [3:0]  o_ready;
   logic        o_valid;
   logic [15:0] o_data;
   logic [1:0]  o_src;
   logic        ready;

   // N_IN = 3 instance
   logic [2:0]  o_ready3;
   logic        o_valid3;
   logic [15:0] o_data3;
   logic [1:0]  o_src3;

   localparam logic [63:0] C_DATA = {16'hD003, 16'hBEEF, 16'hB001, 16'hA000};

   int n_cmp = 0;
   int n_err = 0;

   mux_arb_n #(.WIDTH(WIDTH), .N_IN(4)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_mode  (mode),
      .i_sel   (sel),
      .i_valid (valid),
      .i_data  (data),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_src   (o_src),
      .i_ready (ready)
   );

   mux_arb_n #(.WIDTH(WIDTH), .N_IN(3)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_mode  (1'b0),
      .i_sel   (2'd3),
      .i_valid (3'b111),
      .i_data  (48'h3333_2222_1111),
      .o_ready (o_ready3),
      .o_valid (o_valid3),
      .o_data  (o_data3),
      .o_src   (o_src3),
      .i_ready (1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic        ready;
      logic [3:0]  exp_rdy;
      logic        exp_vld;
      logic [15:0] exp_data;
      logic [1:0]  exp_src;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic r, input logic [3:0] er, input logic ev,
                      input logic [15:0] ed, input logic [1:0] es);
      vec_t t;
      t.mode = m; t.sel = s; t.valid = v; t.ready = r;
      t.exp_rdy = er; t.exp_vld = ev; t.exp_data = ed; t.exp_src = es;
      vq.push_back(t);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      // Idle inputs during reset
      rst_n = 1'b0;
      mode  = 1'b0;
      sel   = 2'd0;
      valid = 4'b0000;
      data  = C_DATA;
      ready = 1'b0;

      #2;
      check("reset o_valid", 64'(o_valid), 64'd0);
      check("reset o_data",  64'(o_data),  64'd0);
      check("reset o_src",   64'(o_src),   64'd0);
      check("reset o_ready", 64'(o_ready), 64'd0);

      #20 rst_n = 1'b1;

      //   mode sel valid  rdy  exp_rdy vld data      src
      // static select, streaming every cycle
      add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2);
      add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2);
      // round-robin, all valid: 0,1,2,3,0,1 (pointer starts at 3)
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hB001, 2'd1);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hB001, 2'd1);
      // round-robin, valid 1010: 3,1,3,1
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'hB001, 2'd1);
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'hB001, 2'd1);
      // backpressure 3 cycles: hold, no ready; pointer stays at 1
      add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hB001, 2'd1);
      add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hB001, 2'd1);
      add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hB001, 2'd1);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2);
      // static select of an invalid channel: drain, data/src kept
      add(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2);
      add(1'b0, 2'd1, 4'b1101, 1'b0, 4'b0000, 1'b0, 16'hBEEF, 2'd2);
      // empty register loads even with i_ready=0, then stalls
      add(1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hD003, 2'd3);
      add(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      // mode switch: RR grant 1 (pointer 2 -> search 3,0,1), static 3 x2, RR -> 2
      add(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 16'hB001, 2'd1);
      add(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2);

      @(posedge clk); #1;
      for (int i = 0; i < vq.size(); i++) begin
         mode  = vq[i].mode;
         sel   = vq[i].sel;
         valid = vq[i].valid;
         ready = vq[i].ready;
         #1;
         check($sformatf("vec%0d o_ready", i), 64'(o_ready), 64'(vq[i].exp_rdy));
         @(posedge clk); #1;
         check($sformatf("vec%0d o_valid", i), 64'(o_valid), 64'(vq[i].exp_vld));
         check($sformatf("vec%0d o_data", i),  64'(o_data),  64'(vq[i].exp_data));
         check($sformatf("vec%0d o_src", i),   64'(o_src),   64'(vq[i].exp_src));
      end

      // Load 0x1234 from channel 1, then reset asynchronously between edges
      data  = {16'hD003, 16'hBEEF, 16'h1234, 16'hA000};
      mode  = 1'b0;
      sel   = 2'd1;
      valid = 4'b0010;
      ready = 1'b1;
      @(posedge clk); #1;
      check("pre-reset o_data",  64'(o_data),  64'h1234);
      check("pre-reset o_valid", 64'(o_valid), 64'd1);
      valid = 4'b0000;
      ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async reset o_valid", 64'(o_valid), 64'd0);
      check("async reset o_data",  64'(o_data),  64'd0);
      check("async reset o_src",   64'(o_src),   64'd0);
      check("async reset o_ready", 64'(o_ready), 64'd0);
      #2 rst_n = 1'b1;
      data  = C_DATA;
      mode  = 1'b1;
      valid = 4'b1111;
      ready = 1'b1;
      #1;
      check("post-reset rr o_ready", 64'(o_ready), 64'b0001);
      @(posedge clk); #1;
      check("post-reset rr o_src",  64'(o_src),  64'd0);
      check("post-reset rr o_data", 64'(o_data), 64'hA000);

      // N_IN=3 with static i_sel=3: never a transfer
      for (int i = 0; i < 5; i++) begin
         check($sformatf("n3 sel3 o_ready cyc%0d", i), 64'(o_ready3), 64'd0);
         check($sformatf("n3 sel3 o_valid cyc%0d", i), 64'(o_valid3), 64'd0);
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- N-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. Generalises the combinational 2:1 select to N channels.
- Two select modes:
  - static: external select index.
  - round-robin: fair arbitration among valid channels.
- One output register stage decouples timing.
- Used to route carry/partial-result streams between SIMD lanes in lse_mult_simd and similar datapaths.

Parameters:
- WIDTH, 16, data width per channel.
- N_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(N_IN), select/source index width. Derived; never overridden.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_mode  input  1  0 = static select, 1 = round-robin.
- i_sel  input  SEL_W  channel index used in static mode.
- i_valid  input  N_IN  per-channel data valid.
- i_data  input  N_IN*WIDTH  packed channel data; channel k at [k*WIDTH +: WIDTH].
- o_ready  output  N_IN  per-channel accept strobe; a transfer on channel k occurs when i_valid[k] && o_ready[k].
- o_valid  output  1  output register holds valid data.
- o_data  output  WIDTH  registered selected data.
- o_src  output  SEL_W  index of the channel that produced o_data.
- i_ready  input  1  downstream accepts o_data when o_valid && i_ready.

Behaviour:
- Reset (i_rst_n=0, asynchronous, any cycle including mid-transfer):
  - o_valid=0, o_data=0, o_src=0.
  - round-robin pointer rr_ptr=N_IN-1, so the first search starts at channel 0.
  - o_ready is combinational and equals 0 while o_valid=0 and no channel is valid.
- load_en = !o_valid || i_ready. The register accepts new data when empty or when draining in the same cycle, giving full throughput of 1 transfer/cycle.
- Grant, combinational, at most one channel:
  - Static mode: grant = i_sel when i_sel < N_IN and i_valid[i_sel]=1, else none. Out-of-range i_sel (non-power-of-2 N_IN) gives no grant and no error.
  - Round-robin mode: search channels rr_ptr+1, rr_ptr+2, … with wrap modulo N_IN. Grant the first with i_valid=1; none if i_valid=0.
- o_ready[k] = load_en && (grant == k). All other bits are 0.
  - o_ready depends combinationally on i_ready and i_valid; upstream must not make i_valid depend on o_ready.
- On a transfer (grant exists && load_en), next edge: o_valid<=1, o_data<=channel data, o_src<=grant.
  - In round-robin mode, rr_ptr<=grant.
- rr_ptr changes only on a round-robin transfer. Static-mode transfers and stalls leave it unchanged.
- No grant && i_ready && o_valid: next edge o_valid<=0. o_data and o_src keep their last value.
- Stall (o_valid && !i_ready): o_valid, o_data and o_src hold stable; all o_ready=0; no input consumed.
- Latency: 1 cycle from input transfer to o_valid.
- i_mode and i_sel may change any cycle. They affect only the next grant, never the held output.
- Simultaneous drain and load: the downstream takes the old o_data while the new data loads on the same edge. No bubble, no loss, no duplication.
- Data is never altered: o_data is exactly the WIDTH bits of the granted channel.

Test Plan:
- Reset mid-stream: (N_IN=4, WIDTH=16) o_valid=1, o_data=0x1234, assert i_rst_n=0 between edges -> o_valid=0, o_data=0, o_src=0 immediately. After release with all channels valid in RR mode, the first o_src=0.
- Static select: i_mode=0, i_sel=2, i_valid=4'b1111, ch2=0xBEEF, i_ready=1 -> o_ready=4'b0100. Next cycle o_valid=1, o_data=0xBEEF, o_src=2. The stream continues every cycle.
- Round-robin fairness: i_mode=1, i_valid=4'b1111 held, i_ready=1 -> o_src sequence 0,1,2,3,0,1 on consecutive cycles. With i_valid=4'b1010 -> 1,3,1,3.
- Backpressure: RR streaming, i_ready=0 for 3 cycles with o_data=0x0002/o_src=2 -> o_data/o_src stable, o_ready=4'b0000 for 3 cycles. After i_ready=1, next o_src=3 (pointer not advanced during stall).
- No grant / drain: i_mode=0, i_sel=1, i_valid=4'b1101, o_valid=1, i_ready=1 -> o_ready=0000, o_valid=0 next cycle, o_data unchanged. N_IN=3 with i_sel=3 -> no transfer ever.
- Mode switch: RR with last grant 1, switch to i_mode=0, i_sel=3 for 2 transfers, then back to RR with all valid -> o_src=3,3, then 2 (rr_ptr still 1).
